soda_dispenser: RTL and testbench



---
 rtl/soda_dispenser_pkg.sv | 91 +++++++++
 rtl/soda_dispenser.sv | 53 +++++
 tb/tb_soda_dispenser.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/soda_dispenser_pkg.sv
// Shared types and helpers for the coin-operated soda dispenser controller.
// Credit states, coin values and the state<->credit / output decode functions.
package soda_dispenser_pkg;

    typedef enum logic [3:0] {
        S0  = 4'd0,
        S5  = 4'd1,
        S10 = 4'd2,
        S15 = 4'd3,
        S20 = 4'd4,
        S25 = 4'd5,
        S30 = 4'd6,
        S35 = 4'd7,
        S40 = 4'd8,
        S45 = 4'd9
    } state_t;

    localparam logic [5:0] PRICE   = 6'd25;
    localparam logic [5:0] NICKEL  = 6'd5;
    localparam logic [5:0] DIME    = 6'd10;
    localparam logic [5:0] QUARTER = 6'd25;

    // Single counted coin per cycle, quarter over dime over nickel.
    function automatic logic [5:0] coin_value(input logic n, input logic d,
                                              input logic q, input logic nm);
        logic [5:0] value;
        if (nm) begin
            value = 6'd0;
        end else if (q) begin
            value = QUARTER;
        end else if (d) begin
            value = DIME;
        end else if (n) begin
            value = NICKEL;
        end else begin
            value = 6'd0;
        end
        return value;
    endfunction

    function automatic logic [5:0] state_credit(input state_t s);
        logic [5:0] credit;
        case (s)
            S0:      credit = 6'd0;
            S5:      credit = 6'd5;
            S10:     credit = 6'd10;
            S15:     credit = 6'd15;
            S20:     credit = 6'd20;
            S25:     credit = 6'd25;
            S30:     credit = 6'd30;
            S35:     credit = 6'd35;
            S40:     credit = 6'd40;
            S45:     credit = 6'd45;
            default: credit = 6'd0;
        endcase
        return credit;
    endfunction

    function automatic state_t credit_state(input logic [5:0] credit);
        state_t s;
        case (credit)
            6'd0:    s = S0;
            6'd5:    s = S5;
            6'd10:   s = S10;
            6'd15:   s = S15;
            6'd20:   s = S20;
            6'd25:   s = S25;
            6'd30:   s = S30;
            6'd35:   s = S35;
            6'd40:   s = S40;
            6'd45:   s = S45;
            default: s = S0;
        endcase
        return s;
    endfunction

    // Output vector ordered {dis, rn, rd, rtd}.
    function automatic logic [3:0] decode_outputs(input state_t s);
        logic [3:0] outs;
        case (s)
            S25:     outs = 4'b1000;
            S30:     outs = 4'b1100;
            S35:     outs = 4'b1010;
            S40:     outs = 4'b1110;
            S45:     outs = 4'b1001;
            default: outs = 4'b0000;
        endcase
        return outs;
    endfunction

endpackage

// File: rtl/soda_dispenser.sv
// Moore FSM soda vending controller: accumulates coin credit and, at 25c or more,
// pulses dispense plus change-return outputs for exactly one cycle.
module soda_dispenser
    import soda_dispenser_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic n,
    input  logic d,
    input  logic q,
    input  logic nm,
    output logic dis,
    output logic rn,
    output logic rd,
    output logic rtd
);

    state_t     state_r;
    state_t     next_state_s;
    logic [5:0] coin_s;
    logic [3:0] outs_next_s;
    logic [3:0] outs_r;

    // Next-state logic: collecting states add the decoded coin, dispensing states return to S0.
    always_comb begin
        coin_s       = coin_value(n, d, q, nm);
        next_state_s = S0;
        case (state_r)
            S0, S5, S10, S15, S20: next_state_s = credit_state(state_credit(state_r) + coin_s);
            S25, S30, S35, S40, S45: next_state_s = S0;
            default:               next_state_s = S0;
        endcase
        outs_next_s = decode_outputs(next_state_s);
    end

    // State and output registers; outputs hold the decode of the state being entered,
    // so they match a pure Moore decode of state_r without any combinational input path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S0;
            outs_r  <= 4'b0000;
        end else begin
            state_r <= next_state_s;
            outs_r  <= outs_next_s;
        end
    end

    assign dis = outs_r[3];
    assign rn  = outs_r[2];
    assign rd  = outs_r[1];
    assign rtd = outs_r[0];

endmodule

// File: tb/tb_soda_dispenser.sv
// Scoreboard bench for soda_dispenser: a credit-arithmetic model predicts each cycle's
// {dis,rn,rd,rtd}; a monitor pops predictions and compares after every rising edge.
module tb_soda_dispenser;

    logic clk;
    logic reset;
    logic n, d, q, nm;
    logic dis, rn, rd, rtd;

    int checks = 0;
    int fails  = 0;
    int credit = 0;
    logic [3:0] exp_q[$];

    soda_dispenser dut (
        .clk  (clk),
        .reset(reset),
        .n    (n),
        .d    (d),
        .q    (q),
        .nm   (nm),
        .dis  (dis),
        .rn   (rn),
        .rd   (rd),
        .rtd  (rtd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs for a given accumulated credit: dispense at 25c, change is credit-25.
    function automatic logic [3:0] expect_for(input int c);
        int change;
        logic [3:0] o;
        o = 4'b0000;
        if (c >= 25) begin
            change = c - 25;
            o[3] = 1'b1;
            o[2] = (change == 5)  || (change == 15);
            o[1] = (change == 10) || (change == 15);
            o[0] = (change == 20);
        end
        return o;
    endfunction

    // One cycle of stimulus: apply inputs at negedge and predict the state after the next edge.
    task automatic drive(input logic vn, input logic vd, input logic vq, input logic vnm);
        int value;
        @(negedge clk);
        n = vn; d = vd; q = vq; nm = vnm;
        if (credit >= 25) begin
            credit = 0;
        end else begin
            value = 0;
            if (!vnm) value = vq ? 25 : (vd ? 10 : (vn ? 5 : 0));
            credit = credit + value;
        end
        exp_q.push_back(expect_for(credit));
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            @(posedge clk);
            #2;
            budget++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
    endtask

    // Monitor: compare DUT outputs against the oldest prediction, 1 time unit after each edge.
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) check("scoreboard", {dis, rn, rd, rtd}, exp_q.pop_front());
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        n = 1'b0; d = 1'b0; q = 1'b0; nm = 1'b1;

        // Reset held low with random coins: outputs stay clear.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n = 1'($urandom); d = 1'($urandom); q = 1'($urandom); nm = 1'($urandom);
            #2;
            check("reset_hold", {dis, rn, rd, rtd}, 4'b0000);
        end
        @(negedge clk);
        n = 1'b0; d = 1'b0; q = 1'b0; nm = 1'b1;
        reset = 1'b1;
        credit = 0;

        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (5) drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Change combinations: 45, 40, 35, 30.
        drive(1'b0, 1'b1, 1'b0, 1'b0); drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0); drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0); drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0); drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0); drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0); drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Priority and nm qualifier.
        drive(1'b1, 1'b1, 1'b1, 1'b0); drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1); drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1); drive(1'b1, 1'b0, 1'b0, 1'b1);

        // Quarter during dispense is discarded; the next quarter dispenses.
        drive(1'b0, 1'b0, 1'b1, 1'b0); drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0); drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // Asynchronous reset between edges at S20.
        repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("async_reset_s20", {dis, rn, rd, rtd}, 4'b0000);
        n = 1'b0; d = 1'b0; q = 1'b0; nm = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        credit = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // Asynchronous reset in the middle of a dispense pulse.
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("async_reset_dispense", {dis, rn, rd, rtd}, 4'b0000);
        n = 1'b0; d = 1'b0; q = 1'b0; nm = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        credit = 0;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
